hex_display_scan: RTL

HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

---
 rtl/hex_display_scan.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hex_display_scan.sv
// Multiplexed seven-segment scanner for a wide hex word: frame-synchronous
// value update, page selection, leading-zero blanking and group separators.
module hex_display_scan #(
  parameter int unsigned DIGITS      = 16,
  parameter int unsigned PHYS        = 8,
  parameter int unsigned REFRESH_DIV = 1000,
  localparam int unsigned PAGES      = DIGITS / PHYS,
  localparam int unsigned PW         = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS*4-1:0] in,
  input  logic              load,
  input  logic [PW-1:0]     page,
  input  logic              blank_lz,
  output logic [PHYS-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              pending
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = (PHYS > 1) ? $clog2(PHYS) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = DIGITS * 4;

  logic [CW-1:0]     presc;
  logic [SW-1:0]     slot;
  logic              tick;
  logic              frame_end;
  logic [VW-1:0]     shadow;
  logic [VW-1:0]     disp;
  logic [PW-1:0]     page_reg;
  logic [PW-1:0]     page_sel;
  logic              blank_reg;
  logic [DW-1:0]     d;
  logic [3:0]        nib;
  logic [DIGITS-1:0] upper_zero;

  assign tick      = (presc == CW'(REFRESH_DIV - 1));
  assign frame_end = tick && (slot == SW'(PHYS - 1));
  assign page_sel  = (32'(page) < PAGES) ? page : '0;
  assign d         = DW'(page_reg) * DW'(PHYS) + DW'(slot);
  assign nib       = disp[{d, 2'b00} +: 4];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h7F;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // upper_zero[k]: every displayed digit from k up to the top is zero
  always_comb begin
    logic z;
    upper_zero = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z = z && (disp[4*k +: 4] == 4'h0);
      upper_zero[k] = z;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      slot  <= '0;
    end else if (tick) begin
      presc <= '0;
      slot  <= (slot == SW'(PHYS - 1)) ? '0 : slot + SW'(1);
    end else begin
      presc <= presc + CW'(1);
    end
  end

  // Shadow capture and frame-boundary transfer; a coincident load stays pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow    <= '0;
      disp      <= '0;
      page_reg  <= '0;
      blank_reg <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (frame_end) begin
        page_reg  <= page_sel;
        blank_reg <= blank_lz;
        if (pending) disp <= shadow;
      end
      if (load) begin
        shadow  <= in;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(PHYS'(1) << slot);
      seg <= (blank_reg && (d != '0) && upper_zero[d]) ? 7'h7F : hex7(nib);
      dp  <= !(((32'(d) & 32'd3) == 32'd0) && (d != '0));
    end
  end

endmodule
